// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 convolution over one 3-row band: a column window feeds a 9-tap
// serial MAC, and each result is saturated (optionally ReLU'd) and written out by address.
module conv3x3_stream_engine #(
    parameter int BIT_DEPTH  = 8,
    parameter int ACC_WIDTH  = 20,
    parameter int IMG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            stride,
    input  logic                  relu_en,
    input  logic [ADDR_WIDTH-1:0] dest_base,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIT_DEPTH-1:0]  in_l1,
    input  logic [BIT_DEPTH-1:0]  in_l2,
    input  logic [BIT_DEPTH-1:0]  in_l3,
    output logic [3:0]            kernel_addr,
    input  logic [BIT_DEPTH-1:0]  kernel_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [BIT_DEPTH-1:0]  out_data,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W = $clog2(IMG_WIDTH + 1);
    localparam int PROD_W = 2 * BIT_DEPTH + 1;
    localparam int NOUT_S1 = IMG_WIDTH - 2;
    localparam int NOUT_S2 = (IMG_WIDTH - 3) / 2 + 1;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-BIT_DEPTH+1){1'b0}}, {(BIT_DEPTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-BIT_DEPTH+1){1'b1}}, {(BIT_DEPTH-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_MAC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                       state_r, state_nxt_s;
    logic [1:0]                   need_r;
    logic [IDX_W-1:0]             idx_r;
    logic                         stride2_r;
    logic                         relu_r;
    logic [ADDR_WIDTH-1:0]        base_r;
    logic [BIT_DEPTH-1:0]         win_r [0:2][0:2];  // [column][row], column 0 oldest
    logic signed [ACC_WIDTH-1:0]  acc_r;
    logic [3:0]                   kaddr_r;
    logic                         in_ready_r, out_valid_r, busy_r, done_r;
    logic [ADDR_WIDTH-1:0]        out_addr_r;
    logic [BIT_DEPTH-1:0]         out_data_r;

    logic                         accept_s;
    logic                         last_tap_s;
    logic                         last_idx_s;
    logic [BIT_DEPTH-1:0]         tap_pix_s;
    logic [PROD_W-1:0]            prod_s;
    logic signed [ACC_WIDTH-1:0]  prod_ext_s;
    logic signed [ACC_WIDTH-1:0]  acc_sum_s;

    // ReLU first, then clamp to the signed output range.
    function automatic logic [BIT_DEPTH-1:0] sat_result(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic                        relu
    );
        logic [BIT_DEPTH-1:0] r;
        if (relu && a[ACC_WIDTH-1]) begin
            r = {BIT_DEPTH{1'b0}};
        end else if (a > SAT_MAX) begin
            r = SAT_MAX[BIT_DEPTH-1:0];
        end else if (a < SAT_MIN) begin
            r = SAT_MIN[BIT_DEPTH-1:0];
        end else begin
            r = a[BIT_DEPTH-1:0];
        end
        return r;
    endfunction

    assign accept_s   = in_valid && in_ready_r;
    assign last_tap_s = (kaddr_r == 4'd8);
    assign last_idx_s = stride2_r ? (idx_r == IDX_W'(NOUT_S2 - 1))
                                  : (idx_r == IDX_W'(NOUT_S1 - 1));

    // Row-major tap k reads row k/3 of window column k%3.
    always_comb begin
        tap_pix_s = {BIT_DEPTH{1'b0}};
        case (kaddr_r)
            4'd0:    tap_pix_s = win_r[0][0];
            4'd1:    tap_pix_s = win_r[1][0];
            4'd2:    tap_pix_s = win_r[2][0];
            4'd3:    tap_pix_s = win_r[0][1];
            4'd4:    tap_pix_s = win_r[1][1];
            4'd5:    tap_pix_s = win_r[2][1];
            4'd6:    tap_pix_s = win_r[0][2];
            4'd7:    tap_pix_s = win_r[1][2];
            4'd8:    tap_pix_s = win_r[2][2];
            default: tap_pix_s = {BIT_DEPTH{1'b0}};
        endcase
    end

    // Unsigned pixel times signed tap, both extended so the truncated product is exact.
    assign prod_s = {{(BIT_DEPTH+1){1'b0}}, tap_pix_s}
                  * {{(BIT_DEPTH+1){kernel_in[BIT_DEPTH-1]}}, kernel_in};
    assign prod_ext_s = {{(ACC_WIDTH-PROD_W){prod_s[PROD_W-1]}}, prod_s};
    assign acc_sum_s  = acc_r + prod_ext_s;

    // Next-state decode for the band sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_FILL;
                else       state_nxt_s = ST_IDLE;
            end
            ST_FILL: begin
                if (accept_s && (need_r == 2'd1)) state_nxt_s = ST_MAC;
                else                              state_nxt_s = ST_FILL;
            end
            ST_MAC: begin
                if (last_tap_s) state_nxt_s = ST_WRITE;
                else            state_nxt_s = ST_MAC;
            end
            ST_WRITE: begin
                if (out_ready) state_nxt_s = last_idx_s ? ST_DONE : ST_FILL;
                else           state_nxt_s = ST_WRITE;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, handshake outputs, config latches, MAC accumulator and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            need_r      <= 2'd0;
            idx_r       <= {IDX_W{1'b0}};
            stride2_r   <= 1'b0;
            relu_r      <= 1'b0;
            base_r      <= {ADDR_WIDTH{1'b0}};
            acc_r       <= {ACC_WIDTH{1'b0}};
            kaddr_r     <= 4'd0;
            out_addr_r  <= {ADDR_WIDTH{1'b0}};
            out_data_r  <= {BIT_DEPTH{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_FILL);
            out_valid_r <= (state_nxt_s == ST_WRITE);
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= (state_nxt_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        stride2_r <= (stride == 2'd2);
                        relu_r    <= relu_en;
                        base_r    <= dest_base;
                        need_r    <= 2'd3;
                        idx_r     <= {IDX_W{1'b0}};
                    end
                end
                ST_FILL: begin
                    if (accept_s) begin
                        need_r  <= need_r - 2'd1;
                        acc_r   <= {ACC_WIDTH{1'b0}};
                        kaddr_r <= 4'd0;
                    end
                end
                ST_MAC: begin
                    acc_r <= acc_sum_s;
                    if (last_tap_s) begin
                        kaddr_r    <= 4'd0;
                        out_data_r <= sat_result(acc_sum_s, relu_r);
                        out_addr_r <= base_r + ADDR_WIDTH'(idx_r);
                    end else begin
                        kaddr_r <= kaddr_r + 4'd1;
                    end
                end
                ST_WRITE: begin
                    if (out_ready && !last_idx_s) begin
                        idx_r  <= idx_r + IDX_W'(1);
                        need_r <= stride2_r ? 2'd2 : 2'd1;
                    end
                end
                ST_DONE: begin
                    need_r <= 2'd0;
                end
                default: begin
                    need_r <= 2'd0;
                end
            endcase
        end
    end

    // Column window: every accepted column enters at column 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                for (int r = 0; r < 3; r++) begin
                    win_r[c][r] <= {BIT_DEPTH{1'b0}};
                end
            end
        end else if (accept_s) begin
            for (int r = 0; r < 3; r++) begin
                win_r[0][r] <= win_r[1][r];
                win_r[1][r] <= win_r[2][r];
            end
            win_r[2][0] <= in_l1;
            win_r[2][1] <= in_l2;
            win_r[2][2] <= in_l3;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign kernel_addr = kaddr_r;
    assign out_addr    = out_addr_r;
    assign out_data    = out_data_r;

endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Bench for conv3x3_stream_engine: directed and random bands checked against
// an arithmetic model of the convolution, saturation and ReLU rules.
module tb_conv3x3_stream_engine;

    localparam int BD = 8;
    localparam int IW = 8;
    localparam int ADW = 5;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [1:0]     stride;
    logic           relu_en;
    logic [ADW-1:0] dest_base;
    logic           in_valid;
    logic           in_ready;
    logic [BD-1:0]  in_l1, in_l2, in_l3;
    logic [3:0]     kernel_addr;
    logic [BD-1:0]  kernel_in;
    logic           out_valid;
    logic           out_ready;
    logic [ADW-1:0] out_addr;
    logic [BD-1:0]  out_data;
    logic           busy;
    logic           done;

    logic [BD-1:0]  kern [0:8];
    int             img  [0:IW-1][0:2];
    int             n_tests;
    int             n_fail;

    conv3x3_stream_engine #(.BIT_DEPTH(BD), .ACC_WIDTH(20), .IMG_WIDTH(IW), .ADDR_WIDTH(ADW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stride(stride), .relu_en(relu_en),
        .dest_base(dest_base), .in_valid(in_valid), .in_ready(in_ready),
        .in_l1(in_l1), .in_l2(in_l2), .in_l3(in_l3),
        .kernel_addr(kernel_addr), .kernel_in(kernel_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_data(out_data), .busy(busy), .done(done)
    );

    assign kernel_in = (kernel_addr < 4'd9) ? kern[kernel_addr] : 8'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_idle_outputs(input string name);
        n_tests++;
        if ({in_ready, out_valid, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s flags: got %b expected 0000", name, {in_ready, out_valid, busy, done});
        end
        n_tests++;
        if ({kernel_addr, out_addr, out_data} !== 17'd0) begin
            n_fail++;
            $display("FAIL %s regs: kaddr=%0d addr=%0d data=%0d expected all 0",
                     name, kernel_addr, out_addr, out_data);
        end
    endtask

    task automatic test_reset();
        check_idle_outputs("reset");
    endtask

    // mode bits: 1 toggle in_valid, 2 random handshakes, 4 stall first write 5 cycles,
    // 8 pulse start while busy, 16 abort by reset during MAC of result 2
    task automatic run_band(input int strd, input int relu, input int base, input int mode,
                            input string name);
        int s, nout, ncols, acc, col, ridx, cyc, stall;
        int exp_d [0:7];
        bit done_seen, held, aborted;
        logic [BD-1:0]  prev_data, exp8;
        logic [ADW-1:0] prev_addr, exp_a;

        s = (strd == 2) ? 2 : 1;
        nout = (IW - 3) / s + 1;
        ncols = 3 + (nout - 1) * s;
        for (int r = 0; r < nout; r++) begin
            acc = 0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    acc += img[r*s + j][i] * int'($signed(kern[i*3 + j]));
            if (relu != 0 && acc < 0) acc = 0;
            if (acc > 127) acc = 127;
            if (acc < -128) acc = -128;
            exp_d[r] = acc;
        end

        @(negedge clk);
        start = 1'b1; stride = 2'(strd); relu_en = (relu != 0); dest_base = ADW'(base);
        col = 0; ridx = 0; cyc = 0; stall = 0;
        done_seen = 1'b0; held = 1'b0; aborted = 1'b0;
        while (!done_seen && !aborted && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if ((mode & 8) != 0 && cyc == 20) begin
                start = 1'b1; stride = 2'd2; relu_en = ~relu_en; dest_base = 5'd0;
            end else begin
                start = 1'b0;
            end
            if (done) done_seen = 1'b1;
            if ((mode & 16) != 0 && ridx == 1 && col >= 4 && busy && !in_ready && !out_valid) begin
                #2 rst_n = 1'b0;
                #1 check_idle_outputs({name, "_abort"});
                aborted = 1'b1;
            end
            if (out_valid) begin
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s in_ready_in_write: got %b expected 0", name, in_ready);
                end
            end
            if (held) begin
                n_tests++;
                if ({out_valid, out_data, out_addr} !== {1'b1, prev_data, prev_addr}) begin
                    n_fail++;
                    $display("FAIL %s hold_stable: got v=%b d=%0d a=%0d expected v=1 d=%0d a=%0d",
                             name, out_valid, out_data, out_addr, prev_data, prev_addr);
                end
            end
            if (col < IW && ((mode & 1) != 0 ? (cyc % 2 == 0) :
                             (mode & 2) != 0 ? ($urandom_range(1, 0) == 1) : 1'b1)) begin
                in_valid = 1'b1;
                in_l1 = BD'(img[col][0]); in_l2 = BD'(img[col][1]); in_l3 = BD'(img[col][2]);
            end else begin
                in_valid = 1'b0;
                in_l1 = BD'($urandom); in_l2 = BD'($urandom); in_l3 = BD'($urandom);
            end
            if ((mode & 4) != 0 && ridx == 0 && stall < 5) begin
                out_ready = 1'b0;
                if (out_valid) stall++;
            end else if ((mode & 2) != 0) begin
                out_ready = ($urandom_range(1, 0) == 1);
            end else begin
                out_ready = 1'b1;
            end
            held = out_valid && !out_ready;
            prev_data = out_data; prev_addr = out_addr;
            if (in_valid && in_ready) col++;
            if (out_valid && out_ready && !aborted) begin
                exp8 = BD'(exp_d[ridx]);
                exp_a = ADW'(base + ridx);
                n_tests++;
                if (out_data !== exp8 || out_addr !== exp_a) begin
                    n_fail++;
                    $display("FAIL %s result[%0d]: got d=%0d a=%0d expected d=%0d a=%0d",
                             name, ridx, $signed(out_data), out_addr, $signed(exp8), exp_a);
                end
                ridx++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        if (aborted) begin
            @(negedge clk);
            check_idle_outputs({name, "_in_reset"});
            rst_n = 1'b1;
        end else begin
            n_tests++;
            if (!done_seen || ridx != nout || col != ncols) begin
                n_fail++;
                $display("FAIL %s completion: got done=%0d results=%0d cols=%0d expected 1/%0d/%0d",
                         name, done_seen, ridx, col, nout, ncols);
            end
            @(negedge clk);
            n_tests++;
            if ({done, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL %s done_pulse: got done=%b busy=%b expected 0 0", name, done, busy);
            end
        end
    endtask

    task automatic fill_const(input int p, input int k);
        for (int c = 0; c < IW; c++)
            for (int r = 0; r < 3; r++) img[c][r] = p;
        for (int t = 0; t < 9; t++) kern[t] = BD'(k);
    endtask

    task automatic test_basic();
        fill_const(1, 1);
        run_band(1, 0, 3, 0, "t1_ones");
    endtask

    task automatic test_stride2();
        fill_const(0, 1);
        for (int c = 0; c < IW; c++)
            for (int r = 0; r < 3; r++) img[c][r] = c;
        run_band(2, 0, 10, 0, "t2_stride2");
    endtask

    task automatic test_saturation();
        fill_const(255, 127);
        run_band(1, 0, 0, 0, "t3_sat_pos");
        fill_const(255, -128);
        run_band(1, 0, 0, 0, "t3_sat_neg");
        run_band(1, 1, 0, 0, "t3_relu");
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < IW; c++)
            for (int r = 0; r < 3; r++) img[c][r] = int'($urandom_range(255, 0));
        for (int t = 0; t < 9; t++) kern[t] = BD'($urandom_range(20, 0) - 10);
        run_band(1, 0, 7, 4, "t4_hold");
    endtask

    task automatic test_toggle_and_start();
        fill_const(1, 1);
        run_band(1, 0, 3, 1 | 8, "t5_toggle");
    endtask

    task automatic test_abort();
        fill_const(1, 1);
        run_band(1, 0, 3, 16, "t6_abort");
        run_band(1, 0, 3, 0, "t6_rerun");
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            for (int c = 0; c < IW; c++)
                for (int r = 0; r < 3; r++) img[c][r] = int'($urandom_range(255, 0));
            for (int t = 0; t < 9; t++) kern[t] = BD'($urandom);
            run_band(int'($urandom_range(3, 0)), int'($urandom_range(1, 0)),
                     int'($urandom_range(31, 0)), 2, "rand");
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; start = 1'b0; stride = 2'd1; relu_en = 1'b0; dest_base = 5'd0;
        in_valid = 1'b0; in_l1 = 8'd0; in_l2 = 8'd0; in_l3 = 8'd0; out_ready = 1'b0;
        for (int t = 0; t < 9; t++) kern[t] = 8'd0;
        #23;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
        test_stride2();
        test_saturation();
        test_backpressure();
        test_toggle_and_start();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
